// File: rtl/shape_metrics.sv
// shape_metrics: per-frame area and crack-edge perimeter of a binary mask
// streamed in raster order. Working sums are double-buffered into result
// registers; a small ACCUM/HOLD/EMIT FSM hands results to a downstream stage
// that may stall via busy_in.
//
// Valid/ready: pixels are accepted on every rising edge where pixel_valid_in=1
// (no back-pressure on the input); valid_out is a one-cycle strobe issued only
// when busy_in was sampled low, and area_out/perimeter_out are stable from the
// result copy until the next copy.
//
// Optional feature: define SHAPE_METRICS_MINAREA_EN to silently discard frames
// whose area is below MIN_AREA.
module shape_metrics #(
    parameter int WIDTH    = 180,
    parameter int HEIGHT   = 320,
    parameter int MIN_AREA = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pixel_valid_in,
    input  logic [$clog2(WIDTH)-1:0]      hcount_in,
    input  logic [$clog2(HEIGHT)-1:0]     vcount_in,
    input  logic                          mask_in,
    input  logic                          busy_in,
    output logic [$clog2(WIDTH*HEIGHT):0] area_out,
    output logic [$clog2(WIDTH*HEIGHT):0] perimeter_out,
    output logic                          valid_out,
    output logic                          dropped_out
);
    localparam int HW = $clog2(WIDTH);
    localparam int VW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH*HEIGHT) + 1;
    localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);
`ifdef SHAPE_METRICS_MINAREA_EN
    localparam bit MIN_AREA_EN = 1'b1;
`else
    localparam bit MIN_AREA_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        HOLD  = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    area_q, area_d;
    logic [CW-1:0]    perim_q, perim_d;
    logic [CW-1:0]    res_area_q, res_area_d;
    logic [CW-1:0]    res_perim_q, res_perim_d;
    logic [WIDTH-1:0] line_q, line_d;
    logic             left_q, left_d;
    logic             in_frame_q, in_frame_d;
    logic             dropped_q, dropped_d;

    logic             frame_start;
    logic             frame_end;
    logic             accept;
    logic             left_nb;
    logic             above_nb;
    logic [2:0]       perim_inc;
    logic [CW-1:0]    area_base;
    logic [CW-1:0]    perim_base;

    // Saturating add: clamps at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [2:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {{(CW-2){1'b0}}, b};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    // Pixel datapath: neighbour lookup, working sums, line buffer, result copy.
    always_comb begin
        frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
        frame_end   = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
        left_nb     = (hcount_in == '0) ? 1'b0 : left_q;
        above_nb    = (vcount_in == '0) ? 1'b0 : line_q[hcount_in];
        perim_inc   = {2'b00, mask_in ^ left_nb}
                    + {2'b00, mask_in ^ above_nb}
                    + {2'b00, mask_in && (hcount_in == H_LAST)}
                    + {2'b00, mask_in && (vcount_in == V_LAST)};
        area_base   = frame_start ? '0 : area_q;
        perim_base  = frame_start ? '0 : perim_q;

        area_d     = area_q;
        perim_d    = perim_q;
        line_d     = line_q;
        left_d     = left_q;
        in_frame_d = in_frame_q || frame_start;
        if (pixel_valid_in) begin
            area_d            = sat_add(area_base, {2'b00, mask_in});
            perim_d           = sat_add(perim_base, perim_inc);
            line_d[hcount_in] = mask_in;
            left_d            = mask_in;
        end

        // A frame end only counts if its frame start was seen since reset.
        accept = frame_end && in_frame_d
                 && (!MIN_AREA_EN || (area_d >= CW'(MIN_AREA)));

        res_area_d  = res_area_q;
        res_perim_d = res_perim_q;
        if (accept) begin
            res_area_d  = area_d;
            res_perim_d = perim_d;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            area_q      <= '0;
            perim_q     <= '0;
            res_area_q  <= '0;
            res_perim_q <= '0;
            line_q      <= '0;
            left_q      <= 1'b0;
            in_frame_q  <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            area_q      <= area_d;
            perim_q     <= perim_d;
            res_area_q  <= res_area_d;
            res_perim_q <= res_perim_d;
            line_q      <= line_d;
            left_q      <= left_d;
            in_frame_q  <= in_frame_d;
            dropped_q   <= dropped_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a new result arriving while one is held is a drop.
    always_comb begin
        state_d   = state_q;
        dropped_d = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept) state_d = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    dropped_d = 1'b1;
                end else if (!busy_in) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = accept ? HOLD : ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // FSM outputs.
    always_comb begin
        valid_out     = (state_q == EMIT);
        dropped_out   = dropped_q;
        area_out      = res_area_q;
        perimeter_out = res_perim_q;
    end

endmodule

// File: tb/tb_shape_metrics.sv
// tb_shape_metrics: table-driven frames plus hand-written busy, drop and
// mid-frame reset sequences against shape_metrics on a 24x32 frame.
module tb_shape_metrics;
    localparam int W     = 24;
    localparam int H     = 32;
    localparam int MIN_A = 16;
    localparam int HW    = $clog2(W);
    localparam int VW    = $clog2(H);
    localparam int CW    = $clog2(W*H) + 1;
    localparam int NV    = 10;

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pv    = 1'b0;
    logic [HW-1:0] hc    = '0;
    logic [VW-1:0] vc    = '0;
    logic          mk    = 1'b0;
    logic          busy  = 1'b0;
    logic [CW-1:0] area;
    logic [CW-1:0] perim;
    logic          valid;
    logic          dropped;

    always #5 clk = ~clk;

    shape_metrics #(.WIDTH(W), .HEIGHT(H), .MIN_AREA(MIN_A)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .pixel_valid_in(pv),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .mask_in       (mk),
        .busy_in       (busy),
        .area_out      (area),
        .perimeter_out (perim),
        .valid_out     (valid),
        .dropped_out   (dropped)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int              n_checks  = 0;
    int              n_pass    = 0;
    int              drop_cnt  = 0;
    int              valid_cnt = 0;
    logic [2*CW-1:0] exp_q[$];
    logic [2*CW-1:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int a, input int p);
        exp_q.push_back({CW'(a), CW'(p)});
    endtask

    // Every valid_out strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("area", int'(area), int'(mon_e[2*CW-1:CW]));
                check("perimeter", int'(perim), int'(mon_e[CW-1:0]));
            end
        end
        if (rst_n && dropped) drop_cnt++;
    end

    // ---------------- frame model ----------------
    bit fm [H][W];

    task automatic fill_rect(input int x0, input int y0, input int w, input int h);
        for (int v = 0; v < H; v++)
            for (int x = 0; x < W; x++)
                fm[v][x] = (x >= x0) && (x < x0 + w) && (v >= y0) && (v < y0 + h);
    endtask

    task automatic fill_random();
        for (int v = 0; v < H; v++)
            for (int x = 0; x < W; x++)
                fm[v][x] = ($urandom_range(0, 2) == 0);
    endtask

    // Area and perimeter counted as exposed sides of each object pixel.
    task automatic model(output int a, output int p);
        a = 0;
        p = 0;
        for (int v = 0; v < H; v++)
            for (int x = 0; x < W; x++)
                if (fm[v][x]) begin
                    a++;
                    if (x == 0     || !fm[v][x-1]) p++;
                    if (x == W - 1 || !fm[v][x+1]) p++;
                    if (v == 0     || !fm[v-1][x]) p++;
                    if (v == H - 1 || !fm[v+1][x]) p++;
                end
    endtask

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raster-scan rows r0..r1 with random invalid bubbles carrying junk.
    task automatic drive_rows(input int r0, input int r1);
        for (int v = r0; v <= r1; v++)
            for (int x = 0; x < W; x++) begin
                if ($urandom_range(0, 9) == 0) begin
                    pv = 1'b0;
                    hc = HW'($urandom_range(0, W - 1));
                    vc = VW'($urandom_range(0, H - 1));
                    mk = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                pv = 1'b1;
                hc = HW'(x);
                vc = VW'(v);
                mk = fm[v][x];
                @(posedge clk);
                #1;
            end
        pv = 1'b0;
    endtask

    // Negedges until valid_out is seen (0 on timeout).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        bit rnd;
        int exp_a;
        int exp_p;
    } vec_t;

    vec_t vecs[NV];

    // ---------------- test ----------------
    initial begin
        int a, p, lat, d0, v0, unstable, bad;

        vecs[0] = '{0, 0, 0, 0, 1'b0, 0, 0};        // empty frame
        vecs[1] = '{5, 5, 1, 1, 1'b0, 1, 4};        // single pixel
        vecs[2] = '{0, 0, W, H, 1'b0, 768, 112};    // all ones
        vecs[3] = '{10, 8, 10, 20, 1'b0, 200, 60};  // rectangle
        vecs[4] = '{W-1, H-1, 1, 1, 1'b0, 1, 4};    // bottom-right corner
        vecs[5] = '{0, 0, 1, 1, 1'b0, 1, 4};        // top-left corner
        vecs[6] = '{0, H-1, W, 1, 1'b0, 24, 50};    // bottom row
        vecs[7] = '{0, 0, 1, H, 1'b0, 32, 66};      // left column
        vecs[8] = '{0, 0, 0, 0, 1'b1, 0, 0};        // random
        vecs[9] = '{0, 0, 0, 0, 1'b1, 0, 0};        // random

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_area", int'(area), 0);
        check("reset_perimeter", int'(perim), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_dropped", int'(dropped), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Table-driven frames with busy low: strobe two cycles after last pixel
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rnd) begin
                fill_random();
                model(a, p);
            end else begin
                fill_rect(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
                a = vecs[i].exp_a;
                p = vecs[i].exp_p;
            end
            push_exp(a, p);
            drive_rows(0, H - 1);
            wait_valid(lat);
            check($sformatf("latency_v%0d", i), lat, 2);
            idle(3);
        end

        // Busy held for 100 cycles after frame end
        fill_rect(10, 8, 10, 20);
        push_exp(200, 60);
        busy = 1'b1;
        drive_rows(0, H - 1);
        bad = 0;
        unstable = 0;
        repeat (100) begin
            @(negedge clk);
            if (valid) bad++;
            if (area != CW'(200) || perim != CW'(60)) unstable++;
        end
        check("busy_no_valid", bad, 0);
        check("busy_hold_values", unstable, 0);
        @(posedge clk);
        #1;
        busy = 1'b0;
        wait_valid(lat);
        check("busy_release_latency", lat, 2);
        idle(3);

        // Two frame ends while busy: second overwrites first
        d0 = drop_cnt;
        busy = 1'b1;
        fill_rect(10, 8, 10, 20);
        drive_rows(0, H - 1);
        idle(4);
        check("drop_none_yet", drop_cnt - d0, 0);
        fill_rect(5, 5, 1, 1);
        push_exp(1, 4);
        drive_rows(0, H - 1);
        idle(4);
        check("drop_pulses", drop_cnt - d0, 1);
        busy = 1'b0;
        wait_valid(lat);
        check("drop_release_latency", lat, 2);
        idle(3);

        // One-cycle reset in the middle of a frame
        fill_rect(0, 0, W, H);
        drive_rows(0, 15);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_area", int'(area), 0);
        check("midreset_perimeter", int'(perim), 0);
        check("midreset_valid", int'(valid), 0);
        check("midreset_dropped", int'(dropped), 0);
        v0 = valid_cnt;
        drive_rows(16, H - 1);
        idle(20);
        check("partial_frame_no_valid", valid_cnt - v0, 0);
        fill_rect(3, 7, 4, 2);
        push_exp(8, 12);
        drive_rows(0, H - 1);
        wait_valid(lat);
        check("post_reset_latency", lat, 2);
        idle(5);

        check("queue_empty", exp_q.size(), 0);
        check("total_drops", drop_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shape_metrics.md
SHAPE_METRICS -- requirements
Module: shape_metrics

Interface
REQ-001 SHALL have parameter WIDTH, default 180: frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 320: frame height in pixels.
REQ-003 SHALL have parameter MIN_AREA, default 16: minimum reported area; used only under REQ-030.
REQ-004 SHALL have port clk_in  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1: synchronous, active-low reset.
REQ-006 SHALL have port pixel_valid_in  input  1: hcount_in, vcount_in and mask_in are valid this cycle.
REQ-007 SHALL have port hcount_in  input  $clog2(WIDTH): pixel column, raster order.
REQ-008 SHALL have port vcount_in  input  $clog2(HEIGHT): pixel row, raster order.
REQ-009 SHALL have port mask_in  input  1: 1 = object pixel.
REQ-010 SHALL have port busy_in  input  1: downstream circularity stage busy.
REQ-011 SHALL have port area_out  output  $clog2(WIDTH*HEIGHT)+1: object pixel count of the last completed frame.
REQ-012 SHALL have port perimeter_out  output  $clog2(WIDTH*HEIGHT)+1: crack-edge perimeter of the last completed frame.
REQ-013 SHALL have port valid_out  output  1: one-cycle strobe; area_out and perimeter_out are valid.
REQ-014 SHALL have port dropped_out  output  1: one-cycle strobe; an unsent result was overwritten.

Function
REQ-015 SHALL treat a valid pixel at (0,0) as frame start: working counters load that pixel's contribution, discarding prior sums.
REQ-016 SHALL add mask_in to working area for every valid pixel.
REQ-017 SHALL add to working perimeter, per valid pixel: (mask != left neighbour) + (mask != above neighbour) + mask when hcount=WIDTH-1 + mask when vcount=HEIGHT-1.
REQ-018 SHALL treat the left neighbour as 0 at hcount=0 and the above neighbour as 0 at vcount=0; per-pixel increment range is 0..4.
REQ-019 SHALL hold the above neighbour in a WIDTH-bit line buffer, read then written at hcount_in each valid pixel.
REQ-020 SHALL saturate both counters at all-ones, with no wrap-around.
REQ-021 SHALL treat a valid pixel at (WIDTH-1, HEIGHT-1) as frame end: at cycle N+1 the final sums including that pixel SHALL be copied to the result registers and the FSM SHALL enter HOLD.
REQ-022 SHALL implement FSM states ACCUM, HOLD and EMIT; reset state ACCUM.
REQ-023 SHALL transition HOLD->EMIT on the first cycle busy_in=0 is sampled; EMIT SHALL drive valid_out=1 for exactly one cycle, then go to ACCUM.
REQ-024 SHALL hold area_out and perimeter_out stable from entry to HOLD until the next result copy.
REQ-025 SHALL continue pixel accumulation into the working counters during HOLD and EMIT; results are double-buffered.
REQ-026 SHALL, on a frame end while in HOLD, overwrite the results, pulse dropped_out for one cycle and remain in HOLD.
REQ-027 SHALL, on a frame end coinciding with EMIT, complete the current strobe and then enter HOLD with the new results.
REQ-028 SHALL give pixels with pixel_valid_in=0 no effect; non-raster input order is undefined behaviour.

Reset
REQ-029 SHALL, when rst_in=0 at a clock edge: set FSM to ACCUM; clear working counters, result registers and line buffer; drive area_out=0, perimeter_out=0, valid_out=0, dropped_out=0; mid-frame data SHALL be discarded and output resumes only after a full frame.

Configuration
REQ-030 SHALL, with SHAPE_METRICS_MINAREA_EN defined, discard a completed frame whose area < MIN_AREA: HOLD not entered, no valid_out, result registers unchanged, no dropped_out; without the macro, every frame is reported.

Verification
REQ-031 SHALL cover: all-zero 180x320 frame, busy_in=0 -> valid_out two cycles after last pixel, area 0, perimeter 0.
REQ-032 SHALL cover: single mask pixel at (5,5) -> area 1, perimeter 4; with SHAPE_METRICS_MINAREA_EN and MIN_AREA=16 -> no valid_out.
REQ-033 SHALL cover: all-ones frame -> area 57600, perimeter 1000; 10x20 rectangle at (40,100) -> area 200, perimeter 60.
REQ-034 SHALL cover: busy_in held high 100 cycles after frame end -> valid_out one cycle after busy_in falls, values unchanged meanwhile.
REQ-035 SHALL cover: busy_in held high across two frame ends (rectangle, then single pixel) -> dropped_out pulse at second end, then valid_out with area 1, perimeter 4.
REQ-036 SHALL cover: rst_in=0 for one cycle mid-frame -> outputs 0, no valid_out for the partial frame, next full frame reported correctly.
